// File: rtl/video_pattern_pkg.sv
// Shared types, colour constants and bar colour lookup for the video test-pattern source.
package video_pattern_pkg;

  localparam int PIXELS_PER_BEAT = 4;

  typedef enum logic [1:0] {
    PATTERN_BARS     = 2'd0,
    PATTERN_GRADIENT = 2'd1,
    PATTERN_CHECKER  = 2'd2,
    PATTERN_MOVING   = 2'd3
  } pattern_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  localparam logic [23:0] COLOR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] COLOR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] COLOR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] COLOR_GREEN   = 24'h00FF00;
  localparam logic [23:0] COLOR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] COLOR_RED     = 24'hFF0000;
  localparam logic [23:0] COLOR_BLUE    = 24'h0000FF;
  localparam logic [23:0] COLOR_BLACK   = 24'h000000;

  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return COLOR_WHITE;
      3'd1:    return COLOR_YELLOW;
      3'd2:    return COLOR_CYAN;
      3'd3:    return COLOR_GREEN;
      3'd4:    return COLOR_MAGENTA;
      3'd5:    return COLOR_RED;
      3'd6:    return COLOR_BLUE;
      default: return COLOR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/video_pattern_source_if.sv
// Pixel-beat stream: 4 pixels per beat with valid/ready handshake.
interface video_pattern_source_if;
  logic        valid;
  logic        ready;
  logic [63:0] bits_0;
  logic [63:0] bits_1;
  logic [63:0] bits_2;
  logic [63:0] bits_3;

  modport master (output valid, output bits_0, output bits_1, output bits_2, output bits_3,
                  input ready);
  modport slave  (input valid, input bits_0, input bits_1, input bits_2, input bits_3,
                  output ready);
endinterface

// File: rtl/video_pattern_pixel.sv
// Combinational colour of one pixel for the selected pattern.
// VIDEO_PATTERN_BORDER_EN forces the outermost pixels of the frame to white.
module video_pattern_pixel
  import video_pattern_pkg::*;
#(
  parameter int BAR_WIDTH_MOVING = 64,
  parameter int CHECKER_SHIFT    = 5
) (
  input  pattern_e    i_pattern,
  input  logic [15:0] i_xp,
  input  logic [15:0] i_y,
  input  logic [15:0] i_width,
  input  logic [15:0] i_height,
  input  logic [15:0] i_offset,
  input  logic [2:0]  i_bar_index,
  output logic [23:0] o_color
);

  logic [16:0] w_bar_end;
  logic [23:0] w_pattern_color;

  // 17 bits so a bar near the top of the range cannot wrap around
  assign w_bar_end = {1'b0, i_offset} + 17'(BAR_WIDTH_MOVING);

  always_comb begin
    w_pattern_color = COLOR_BLACK;
    case (i_pattern)
      PATTERN_BARS:     w_pattern_color = bar_color(i_bar_index);
      PATTERN_GRADIENT: w_pattern_color = {3{i_xp[7:0]}};
      PATTERN_CHECKER:  w_pattern_color = (i_xp[CHECKER_SHIFT] ^ i_y[CHECKER_SHIFT]) ?
                                          COLOR_WHITE : COLOR_BLACK;
      PATTERN_MOVING:   w_pattern_color = ((i_xp >= i_offset) && ({1'b0, i_xp} < w_bar_end)) ?
                                          COLOR_WHITE : COLOR_BLACK;
      default:          w_pattern_color = COLOR_BLACK;
    endcase
  end

`ifdef VIDEO_PATTERN_BORDER_EN
  logic w_border;
  assign w_border = (i_xp == 16'd0) || (i_xp == i_width - 16'd1) ||
                    (i_y == 16'd0)  || (i_y == i_height - 16'd1);
  assign o_color  = w_border ? COLOR_WHITE : w_pattern_color;
`else
  logic w_unused;
  assign w_unused = ^{i_width, i_height, i_y};
  assign o_color  = w_pattern_color;
`endif

endmodule

// File: rtl/video_pattern_source.sv
// Frame-aligned test-pattern generator emitting 4 pixels per beat.
// Optional VIDEO_PATTERN_BORDER_EN (in video_pattern_pixel) whitens the frame border.
//   state     | meaning
//   ST_IDLE   | no frame in progress, valid low, waiting for start_frame
//   ST_ACTIVE | streaming beats of the current frame
module video_pattern_source
  import video_pattern_pkg::*;
#(
  parameter int BAR_WIDTH_MOVING = 64,
  parameter int MOVE_STEP        = 8,
  parameter int CHECKER_SHIFT    = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [15:0]             i_video_width,
  input  logic [15:0]             i_video_height,
  input  logic [1:0]              i_pattern,
  input  logic                    i_start_frame,
  video_pattern_source_if.master  bus,
  output logic [15:0]             o_frame_count,
  output logic                    o_resync
);

  state_e             r_state, w_state_nxt;
  logic [15:0]        r_x, w_x_nxt;
  logic [15:0]        r_y, w_y_nxt;
  logic [15:0]        r_width, w_width_nxt;
  logic [15:0]        r_height, w_height_nxt;
  logic [15:0]        r_bar_width, w_bar_width_nxt;
  logic [15:0]        r_bar_pos, w_bar_pos_nxt;
  logic [2:0]         r_bar_idx, w_bar_idx_nxt;
  pattern_e           r_pattern, w_pattern_nxt;
  logic [15:0]        r_offset, w_offset_nxt;
  logic [15:0]        r_frame_count, w_frame_count_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_resync, w_resync_nxt;
  logic [3:0][23:0]   r_pix;
  logic [23:0]        w_pix [PIXELS_PER_BEAT];
  logic               w_load;
  logic               w_xfer, w_line_end, w_last, w_done;
  logic [16:0]        w_off_step;

  assign w_xfer     = r_valid && bus.ready;
  assign w_line_end = (r_x == r_width - 16'(PIXELS_PER_BEAT));
  assign w_last     = w_line_end && (r_y == r_height - 16'd1);
  assign w_done     = (r_state == ST_ACTIVE) && w_xfer && w_last;
  assign w_off_step = {1'b0, r_offset} + 17'(MOVE_STEP);

  always_comb begin
    w_state_nxt       = r_state;
    w_x_nxt           = r_x;
    w_y_nxt           = r_y;
    w_width_nxt       = r_width;
    w_height_nxt      = r_height;
    w_bar_width_nxt   = r_bar_width;
    w_bar_pos_nxt     = r_bar_pos;
    w_bar_idx_nxt     = r_bar_idx;
    w_pattern_nxt     = r_pattern;
    w_offset_nxt      = r_offset;
    w_frame_count_nxt = r_frame_count;
    w_valid_nxt       = r_valid;
    w_resync_nxt      = 1'b0;
    w_load            = 1'b0;

    // A completing frame is counted even if start_frame arrives in the same cycle
    if (w_done) begin
      w_frame_count_nxt = r_frame_count + 16'd1;
      w_offset_nxt      = (w_off_step >= {1'b0, r_width}) ? 16'd0 : w_off_step[15:0];
    end

    if (i_start_frame) begin
      w_state_nxt     = ST_ACTIVE;
      w_x_nxt         = 16'd0;
      w_y_nxt         = 16'd0;
      w_width_nxt     = i_video_width;
      w_height_nxt    = i_video_height;
      w_bar_width_nxt = i_video_width >> 3;
      w_bar_pos_nxt   = 16'd0;
      w_bar_idx_nxt   = 3'd0;
      w_pattern_nxt   = pattern_e'(i_pattern);
      w_valid_nxt     = 1'b1;
      w_load          = 1'b1;
      w_resync_nxt    = (r_state == ST_ACTIVE) && !w_done;
    end else if ((r_state == ST_ACTIVE) && w_xfer) begin
      if (w_last) begin
        w_state_nxt = ST_IDLE;
        w_valid_nxt = 1'b0;
      end else begin
        w_load = 1'b1;
        if (w_line_end) begin
          w_x_nxt       = 16'd0;
          w_y_nxt       = r_y + 16'd1;
          w_bar_pos_nxt = 16'd0;
          w_bar_idx_nxt = 3'd0;
        end else begin
          w_x_nxt = r_x + 16'(PIXELS_PER_BEAT);
          // bar width is a multiple of 4, so a beat never straddles two bars
          if (r_bar_pos + 16'(PIXELS_PER_BEAT) == r_bar_width) begin
            w_bar_pos_nxt = 16'd0;
            w_bar_idx_nxt = r_bar_idx + 3'd1;
          end else begin
            w_bar_pos_nxt = r_bar_pos + 16'(PIXELS_PER_BEAT);
          end
        end
      end
    end
  end

  for (genvar k = 0; k < PIXELS_PER_BEAT; k++) begin : g_pix
    video_pattern_pixel #(
      .BAR_WIDTH_MOVING (BAR_WIDTH_MOVING),
      .CHECKER_SHIFT    (CHECKER_SHIFT)
    ) u_pixel (
      .i_pattern   (w_pattern_nxt),
      .i_xp        (w_x_nxt + 16'(k)),
      .i_y         (w_y_nxt),
      .i_width     (w_width_nxt),
      .i_height    (w_height_nxt),
      .i_offset    (w_offset_nxt),
      .i_bar_index (w_bar_idx_nxt),
      .o_color     (w_pix[k])
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_x           <= 16'd0;
      r_y           <= 16'd0;
      r_width       <= 16'd0;
      r_height      <= 16'd0;
      r_bar_width   <= 16'd0;
      r_bar_pos     <= 16'd0;
      r_bar_idx     <= 3'd0;
      r_pattern     <= PATTERN_BARS;
      r_offset      <= 16'd0;
      r_frame_count <= 16'd0;
      r_valid       <= 1'b0;
      r_resync      <= 1'b0;
      r_pix         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_x           <= w_x_nxt;
      r_y           <= w_y_nxt;
      r_width       <= w_width_nxt;
      r_height      <= w_height_nxt;
      r_bar_width   <= w_bar_width_nxt;
      r_bar_pos     <= w_bar_pos_nxt;
      r_bar_idx     <= w_bar_idx_nxt;
      r_pattern     <= w_pattern_nxt;
      r_offset      <= w_offset_nxt;
      r_frame_count <= w_frame_count_nxt;
      r_valid       <= w_valid_nxt;
      r_resync      <= w_resync_nxt;
      if (w_load) begin
        for (int k = 0; k < PIXELS_PER_BEAT; k++) r_pix[k] <= w_pix[k];
      end
    end
  end

  assign bus.valid     = r_valid;
  assign bus.bits_0    = {40'd0, r_pix[0]};
  assign bus.bits_1    = {40'd0, r_pix[1]};
  assign bus.bits_2    = {40'd0, r_pix[2]};
  assign bus.bits_3    = {40'd0, r_pix[3]};
  assign o_frame_count = r_frame_count;
  assign o_resync      = r_resync;

endmodule

// File: tb/tb_video_pattern_source.sv
// Scoreboard bench for video_pattern_source: expected beats queued at start_frame, checked on transfer.
module tb_video_pattern_source;

  typedef struct {
    logic [255:0] data;
    bit           last;
    int           width;
  } beat_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] i_video_width;
  logic [15:0] i_video_height;
  logic [1:0]  i_pattern;
  logic        i_start_frame;
  logic [15:0] o_frame_count;
  logic        o_resync;

  video_pattern_source_if bus ();

  video_pattern_source dut (
    .clock          (clock),
    .reset          (reset),
    .i_video_width  (i_video_width),
    .i_video_height (i_video_height),
    .i_pattern      (i_pattern),
    .i_start_frame  (i_start_frame),
    .bus            (bus),
    .o_frame_count  (o_frame_count),
    .o_resync       (o_resync)
  );

  always #5 clock = ~clock;

  beat_t        q[$];
  int           checks = 0;
  int           failures = 0;
  logic [15:0]  m_fc;
  int           m_offset;
  bit           m_active;
  bit           m_resync_exp;
  bit           hold_pending;
  logic [255:0] hold_data;
  logic [255:0] w_obs;

  assign w_obs = {bus.bits_3, bus.bits_2, bus.bits_1, bus.bits_0};

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] model_pix(int pat, int xp, int y, int w, int h, int off);
    logic [23:0] c;
    int idx;
    case (pat)
      0: begin
        idx = xp / (w / 8);
        case (idx)
          0: c = 24'hFFFFFF;
          1: c = 24'hFFFF00;
          2: c = 24'h00FFFF;
          3: c = 24'h00FF00;
          4: c = 24'hFF00FF;
          5: c = 24'hFF0000;
          6: c = 24'h0000FF;
          default: c = 24'h000000;
        endcase
      end
      1: c = 24'h010101 * 24'(xp % 256);
      2: c = ((((xp >> 5) ^ (y >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      default: c = (xp >= off && xp < off + 64) ? 24'hFFFFFF : 24'h000000;
    endcase
`ifdef VIDEO_PATTERN_BORDER_EN
    if (xp == 0 || xp == w - 1 || y == 0 || y == h - 1) c = 24'hFFFFFF;
`endif
    return c;
  endfunction

  task automatic push_frame(input int pat, input int w, input int h);
    beat_t b;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x += 4) begin
        b.data = '0;
        for (int k = 0; k < 4; k++)
          b.data[k*64 +: 64] = {40'd0, model_pix(pat, x + k, y, w, h, m_offset)};
        b.last  = (x == w - 4) && (y == h - 1);
        b.width = w;
        q.push_back(b);
      end
    end
  endtask

  // One clock cycle: drive inputs, check outputs of the previous edge, consume a transfer.
  task automatic cycle(input bit rdy, input bit sf);
    beat_t e;
    bus.ready     = rdy;
    i_start_frame = sf;
    chk("valid", 256'(bus.valid), 256'(m_active));
    chk("frame_count", 256'(o_frame_count), 256'(m_fc));
    chk("resync", 256'(o_resync), 256'(m_resync_exp));
    if (hold_pending) chk("stall_hold", w_obs, hold_data);
    hold_pending = bus.valid && !rdy && !sf;
    hold_data    = w_obs;
    if (bus.valid && rdy) begin
      checks++;
      assert (q.size() > 0) else begin
        failures++;
        $error("FAIL unexpected_beat observed=%0h expected=none", w_obs);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("beat", w_obs, e.data);
        if (e.last) begin
          m_fc++;
          m_offset += 8;
          if (m_offset >= e.width) m_offset = 0;
          m_active = 0;
        end
      end
    end
    m_resync_exp = sf && m_active;
    if (sf) begin
      q.delete();
      push_frame(int'(i_pattern), int'(i_video_width), int'(i_video_height));
      m_active = 1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic run_until(input int remaining, input bit toggle, input int budget, input string tag);
    int n;
    n = 0;
    while (q.size() > remaining && n < budget) begin
      cycle(toggle ? bit'(n % 2 == 0) : 1'b1, 1'b0);
      n++;
    end
    checks++;
    assert (q.size() <= remaining) else begin
      failures++;
      $error("FAIL %s_budget observed=%0d expected<=%0d", tag, q.size(), remaining);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    chk("rst_valid", 256'(bus.valid), 256'(0));
    chk("rst_bits", w_obs, 256'(0));
    chk("rst_frame_count", 256'(o_frame_count), 256'(0));
    chk("rst_resync", 256'(o_resync), 256'(0));
    q.delete();
    m_fc = 0; m_offset = 0; m_active = 0; m_resync_exp = 0; hold_pending = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic setup(input int pat, input int w, input int h);
    i_pattern      = 2'(pat);
    i_video_width  = 16'(w);
    i_video_height = 16'(h);
  endtask

  initial begin
    reset = 1'b1;
    bus.ready = 1'b1;
    i_start_frame = 1'b0;
    setup(0, 64, 2);
    m_fc = 0; m_offset = 0; m_active = 0; m_resync_exp = 0; hold_pending = 0;
    #1;
    do_reset();
    idle(3);

    // colour bars, full throughput
    setup(0, 64, 2);
    cycle(1'b1, 1'b1);
    run_until(0, 1'b0, 100, "bars");
    idle(3);

    // gradient under alternating backpressure
    setup(1, 1920, 1);
    cycle(1'b1, 1'b1);
    run_until(0, 1'b1, 1000, "gradient");
    idle(2);

    // checkerboard
    setup(2, 128, 64);
    cycle(1'b1, 1'b1);
    run_until(0, 1'b0, 2200, "checker");
    idle(2);

    setup(2, 64, 4);
    cycle(1'b1, 1'b1);
    run_until(0, 1'b0, 100, "checker_small");
    idle(2);

    // start_frame mid-frame with a stalled beat pending
    setup(0, 64, 2);
    cycle(1'b1, 1'b1);
    run_until(22, 1'b0, 50, "pre_resync");
    cycle(1'b0, 1'b1);
    run_until(0, 1'b0, 100, "post_resync");
    idle(2);

    // reset while a frame is in flight
    setup(3, 128, 1);
    cycle(1'b1, 1'b1);
    run_until(27, 1'b0, 50, "pre_reset");
    do_reset();
    idle(2);

    // moving bar across enough frames for the offset to wrap; frame 5 ends coincident with start_frame
    setup(3, 128, 1);
    for (int f = 0; f < 18; f++) begin
      cycle(1'b1, 1'b1);
      if (f == 5) begin
        run_until(1, 1'b0, 100, "moving_coincident");
      end else begin
        run_until(0, 1'b0, 100, "moving");
        idle(1);
      end
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
